// File: rtl/pic_fetch_unit_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP encoding and PC source selection.
package pic_fetch_unit_pkg;

  localparam int          INSTR_W = 14;
  localparam logic [13:0] ISA_NOP = 14'h0000;

  // Source of the next PC value, one per cycle.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INCR = 2'd1,
    PC_POP  = 2'd2,
    PC_LOAD = 2'd3
  } pc_sel_e;

  // A branch target beats a return, which beats the sequential increment.
  function automatic pc_sel_e pc_select(input logic load, input logic pop, input logic incr);
    pc_sel_e sel;
    if (load) begin
      sel = PC_LOAD;
    end else if (pop) begin
      sel = PC_POP;
    end else if (incr) begin
      sel = PC_INCR;
    end else begin
      sel = PC_HOLD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pic_fetch_unit_hw_stack.sv
// Circular hardware return stack with PIC wrap semantics and sticky overflow/underflow flags.
// Storage is deliberately not reset; only the pointer, occupancy and flags are.
module pic_hw_stack
  import pic_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_overflow,
  output logic         o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W-1:0] w_top_idx;

  // A simultaneous push and pop is treated as a pop only.
  always_comb begin
    w_do_pop  = i_pop;
    w_do_push = i_push & ~i_pop;
    w_full    = (r_count == CNT_W'(DEPTH));
    w_empty   = (r_count == CNT_W'(0));
    w_top_idx = r_ptr - PTR_W'(1);
  end

  // Pointer, saturating occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= PTR_W'(0);
      r_count     <= CNT_W'(0);
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - PTR_W'(1);
      if (w_empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Entry storage; a push during reset must not disturb existing contents.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

  assign o_top       = r_mem[w_top_idx];
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register with branch flush,
// and the hardware return stack used by CALL/RETURN.
module pic_fetch_unit
  import pic_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 13,
  parameter int                  STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_incr_pc_en,
  input  logic                i_instr_rd_en,
  input  logic                i_pc_load_en,
  input  logic [PC_WIDTH-1:0] i_pc_load_addr,
  input  logic                i_stack_push_en,
  input  logic                i_stack_pop_en,
  input  logic                i_flush_en,
  input  logic [INSTR_W-1:0]  i_prog_data,
  output logic [PC_WIDTH-1:0] o_prog_addr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [INSTR_W-1:0]  o_instr_current,
  output logic                o_stack_overflow,
  output logic                o_stack_underflow
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_flush_pending;

  logic [PC_WIDTH-1:0] w_pc_next;
  logic [INSTR_W-1:0]  w_ir_next;
  logic                w_flush_next;
  logic [PC_WIDTH-1:0] w_stack_top;

  // Return stack: pushes the PC as it stands before this cycle's update.
  pic_hw_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_WIDTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (i_stack_push_en),
    .i_pop       (i_stack_pop_en),
    .i_push_data (r_pc),
    .o_top       (w_stack_top),
    .o_overflow  (o_stack_overflow),
    .o_underflow (o_stack_underflow)
  );

  // Next PC by priority; the increment wraps naturally at the register width.
  always_comb begin
    w_pc_next = r_pc;
    case (pc_select(i_pc_load_en, i_stack_pop_en, i_incr_pc_en))
      PC_LOAD: w_pc_next = i_pc_load_addr;
      PC_POP:  w_pc_next = w_stack_top;
      PC_INCR: w_pc_next = r_pc + PC_WIDTH'(1);
      PC_HOLD: w_pc_next = r_pc;
      default: w_pc_next = r_pc;
    endcase
  end

  // Next IR and flush state: a pending or same-cycle flush turns the fetch into a NOP.
  always_comb begin
    w_ir_next    = r_ir;
    w_flush_next = r_flush_pending;
    if (i_instr_rd_en) begin
      if (i_flush_en || r_flush_pending) begin
        w_ir_next = ISA_NOP;
      end else begin
        w_ir_next = i_prog_data;
      end
      w_flush_next = 1'b0;
    end else if (i_flush_en) begin
      w_flush_next = 1'b1;
    end else begin
      w_flush_next = r_flush_pending;
    end
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= RESET_VECTOR;
      r_ir            <= ISA_NOP;
      r_flush_pending <= 1'b0;
    end else begin
      r_pc            <= w_pc_next;
      r_ir            <= w_ir_next;
      r_flush_pending <= w_flush_next;
    end
  end

  assign o_prog_addr     = r_pc;
  assign o_pc            = r_pc;
  assign o_instr_current = r_ir;

endmodule
